// File: rtl/friscv_pmp_pkg.sv
// Shared PMP encodings: cfg byte fields, privilege levels, access types.
package friscv_pmp_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_a_e;

  localparam int PMP_L     = 7;
  localparam int PMP_A_MSB = 4;
  localparam int PMP_A_LSB = 3;
  localparam int PMP_X     = 2;
  localparam int PMP_W     = 1;
  localparam int PMP_R     = 0;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  typedef struct packed {
    logic       allow;
    logic       match;
    logic [3:0] region;
  } pmp_rsp_t;

  function automatic logic acc_legal(logic [2:0] t);
    return (t == ACC_R) || (t == ACC_W) || (t == ACC_X);
  endfunction

endpackage

// File: rtl/friscv_pmp_if.sv
// Request/response handshake between address generation and the PMP checker.
interface friscv_pmp_if #(
  parameter int AXI_ADDR_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [AXI_ADDR_W-1:0] req_addr;
  logic [2:0]            req_type;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_allow;
  logic                  rsp_match;
  logic [3:0]            rsp_region;

  modport master (
    output req_valid, req_addr, req_type, rsp_ready,
    input  req_ready, rsp_valid, rsp_allow, rsp_match, rsp_region
  );

  modport slave (
    input  req_valid, req_addr, req_type, rsp_ready,
    output req_ready, rsp_valid, rsp_allow, rsp_match, rsp_region
  );
endinterface

// File: rtl/friscv_pmp_region.sv
// Single PMP entry matcher: address-range hit plus effective R/W/X bits.
module friscv_pmp_region
  import friscv_pmp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [7:0]      cfg,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] prev_addr,
  input  logic [XLEN-1:0] a,
  output logic            match,
  output logic [2:0]      rwx
);

  logic [XLEN-1:0] mask;
  logic            cfg_unused;

  // NAPOT: trailing ones of addr plus the next zero form the don't-care mask
  assign mask       = addr ^ (addr + XLEN'(1));
  assign cfg_unused = ^cfg[7:5];

  always_comb begin
    match = 1'b0;
    case (pmp_a_e'(cfg[PMP_A_MSB:PMP_A_LSB]))
      PMP_TOR:   match = (a >= prev_addr) && (a < addr);
      PMP_NA4:   match = (a == addr);
      PMP_NAPOT: match = ((a | mask) == (addr | mask));
      default:   match = 1'b0;
    endcase
  end

  // W without R is reserved: both read and write are withheld
  assign rwx = {cfg[PMP_X], cfg[PMP_W] & cfg[PMP_R], cfg[PMP_R]};

endmodule

// File: rtl/friscv_pmp_checker.sv
// PMP checker: per-entry matchers, lowest-index priority, registered response
// stage and sticky first-fault capture.
module friscv_pmp_checker
  import friscv_pmp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AXI_ADDR_W  = 32,
  parameter int NB_REGIONS  = 16,
  parameter int FAULT_CNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NB_REGIONS*8-1:0]  pmp_cfg,
  input  logic [NB_REGIONS*XLEN-1:0] pmp_addr,
  input  logic [1:0]               priv_mode,
  friscv_pmp_if.slave              bus,
  input  logic                     fault_clear,
  output logic                     fault_valid,
  output logic [AXI_ADDR_W-1:0]    fault_addr,
  output logic [2:0]               fault_type,
  output logic [FAULT_CNT_W-1:0]   fault_count
);

  logic [XLEN-1:0]                 a;
  logic [NB_REGIONS-1:0]           hit;
  logic [NB_REGIONS-1:0][2:0]      rwx;
  logic                            win_hit, win_lock;
  logic [3:0]                      win_idx;
  logic [2:0]                      win_rwx;
  pmp_rsp_t                        rsp_d, rsp_q;
  logic                            rsp_valid_q;
  logic [AXI_ADDR_W-1:0]           req_addr_q;
  logic [2:0]                      req_type_q;
  logic                            accept, deny_hs;
  logic                            fault_valid_q;
  logic [AXI_ADDR_W-1:0]           fault_addr_q;
  logic [2:0]                      fault_type_q;
  logic [FAULT_CNT_W-1:0]          fault_cnt_q;

  assign a = XLEN'(bus.req_addr[AXI_ADDR_W-1:2]);

  for (genvar gi = 0; gi < NB_REGIONS; gi++) begin : g_region
    logic [XLEN-1:0] prev;
    if (gi == 0) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = pmp_addr[XLEN*(gi-1) +: XLEN];
    end
    friscv_pmp_region #(.XLEN(XLEN)) u_region (
      .cfg       (pmp_cfg[8*gi +: 8]),
      .addr      (pmp_addr[XLEN*gi +: XLEN]),
      .prev_addr (prev),
      .a         (a),
      .match     (hit[gi]),
      .rwx       (rwx[gi])
    );
  end

  // Scan from the top so the lowest matching index is the last one written
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_rwx  = '0;
    win_lock = 1'b0;
    for (int i = NB_REGIONS-1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit  = 1'b1;
        win_idx  = 4'(i);
        win_rwx  = rwx[i];
        win_lock = pmp_cfg[8*i + PMP_L];
      end
    end
  end

  always_comb begin
    rsp_d.match  = win_hit;
    rsp_d.region = win_idx;
    if (!acc_legal(bus.req_type))
      rsp_d.allow = 1'b0;
    else if (!win_hit)
      rsp_d.allow = (priv_mode == PRIV_M);
    else if ((priv_mode == PRIV_M) && !win_lock)
      rsp_d.allow = 1'b1;
    else
      rsp_d.allow = |(bus.req_type & win_rwx);
  end

  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign deny_hs       = rsp_valid_q && bus.rsp_ready && !rsp_q.allow;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      req_addr_q  <= '0;
      req_type_q  <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
      req_addr_q  <= bus.req_addr;
      req_type_q  <= bus.req_type;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // A denial in the same cycle as a clear restarts capture with that denial
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_type_q  <= '0;
      fault_cnt_q   <= '0;
    end else if (deny_hs) begin
      if (!fault_valid_q || fault_clear) begin
        fault_addr_q <= req_addr_q;
        fault_type_q <= req_type_q;
      end
      fault_valid_q <= 1'b1;
      if (fault_clear)
        fault_cnt_q <= FAULT_CNT_W'(1);
      else if (!(&fault_cnt_q))
        fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
    end else if (fault_clear) begin
      fault_valid_q <= 1'b0;
      fault_cnt_q   <= '0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_allow  = rsp_q.allow;
  assign bus.rsp_match  = rsp_q.match;
  assign bus.rsp_region = rsp_q.region;
  assign fault_valid    = fault_valid_q;
  assign fault_addr     = fault_addr_q;
  assign fault_type     = fault_type_q;
  assign fault_count    = fault_cnt_q;

endmodule

// File: tb/tb_friscv_pmp_checker.sv
// Randomised and directed bench for friscv_pmp_checker against a byte-range
// reference model with a response queue and fault bookkeeping.
module tb_friscv_pmp_checker;
  import friscv_pmp_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int NR   = 16;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR*8-1:0]   pmp_cfg;
  logic [NR*XLEN-1:0] pmp_addr;
  logic [1:0]        priv_mode;
  logic              fault_clear;
  logic              fault_valid;
  logic [AW-1:0]     fault_addr;
  logic [2:0]        fault_type;
  logic [CW-1:0]     fault_count;

  friscv_pmp_if #(.AXI_ADDR_W(AW)) bus ();

  friscv_pmp_checker #(
    .XLEN(XLEN), .AXI_ADDR_W(AW), .NB_REGIONS(NR), .FAULT_CNT_W(CW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .pmp_cfg     (pmp_cfg),
    .pmp_addr    (pmp_addr),
    .priv_mode   (priv_mode),
    .bus         (bus),
    .fault_clear (fault_clear),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_type  (fault_type),
    .fault_count (fault_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        allow;
    logic        match;
    logic [3:0]  region;
    logic [31:0] addr;
    logic [2:0]  typ;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        m_fv = 1'b0;
  logic [31:0] m_fa = '0;
  logic [2:0]  m_ft = '0;
  int          m_fc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: every region expressed as a byte range [base, base+size)
  function automatic exp_t model(input logic [NR*8-1:0] cfg, input logic [NR*XLEN-1:0] pa,
                                 input logic [1:0] priv, input logic [31:0] addr,
                                 input logic [2:0] typ);
    exp_t            e;
    longint unsigned ba, lo, hi, size, base;
    int              t;
    bit              hit, r, w, x, lck, legal;
    logic [7:0]      c;
    e.allow = 0; e.match = 0; e.region = 0; e.addr = addr; e.typ = typ;
    ba    = 64'(addr);
    legal = (typ == 3'b001) || (typ == 3'b010) || (typ == 3'b100);
    for (int i = 0; i < NR; i++) begin
      c   = cfg[8*i +: 8];
      hi  = 64'(pa[XLEN*i +: XLEN]) << 2;
      hit = 0;
      case (c[4:3])
        2'd1: begin
          lo = 0;
          if (i > 0) lo = 64'(pa[XLEN*(i-1) +: XLEN]) << 2;
          hit = (ba >= lo) && (ba < hi);
        end
        2'd2: hit = (ba >= hi) && (ba < hi + 4);
        2'd3: begin
          t = 0;
          while (t < XLEN && pa[XLEN*i + t]) t++;
          size = 64'd1 << (t + 3);
          base = hi & ~(size - 1);
          hit  = (ba >= base) && (ba < base + size);
        end
        default: hit = 0;
      endcase
      if (hit) begin
        e.match = 1; e.region = 4'(i);
        r = c[0]; w = c[1]; x = c[2]; lck = c[7];
        if (w && !r) w = 0;
        if (!legal)                  e.allow = 0;
        else if (priv == 3 && !lck)  e.allow = 1;
        else                         e.allow = (typ[0] & r) | (typ[1] & w) | (typ[2] & x);
        return e;
      end
    end
    e.allow = legal && (priv == 3);
    return e;
  endfunction

  // Checks every cycle, then advances the model to what the next edge does
  always @(negedge aclk) begin : mon
    exp_t e;
    bit   acc, hs;
    if (!aresetn) begin
      q.delete();
      m_fv = 0; m_fa = '0; m_ft = '0; m_fc = 0;
    end else begin
      chk("req_ready", bus.req_ready, (q.size() == 0) || bus.rsp_ready);
      chk("rsp_valid", bus.rsp_valid, q.size() != 0);
      chk("fault_valid", fault_valid, m_fv);
      chk("fault_count", fault_count, m_fc);
      if (m_fv) begin
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_type", fault_type, m_ft);
      end
      if (q.size() != 0 && bus.rsp_valid) begin
        chk("rsp_allow", bus.rsp_allow, q[0].allow);
        chk("rsp_match", bus.rsp_match, q[0].match);
        chk("rsp_region", bus.rsp_region, q[0].region);
      end
      hs  = (q.size() != 0) && bus.rsp_ready;
      acc = bus.req_valid && ((q.size() == 0) || bus.rsp_ready);
      if (hs) e = q.pop_front();
      if (hs && !e.allow) begin
        if (!m_fv || fault_clear) begin
          m_fa = e.addr; m_ft = e.typ;
        end
        m_fv = 1;
        m_fc = fault_clear ? 1 : ((m_fc < CMAX) ? m_fc + 1 : CMAX);
      end else if (fault_clear) begin
        m_fv = 0; m_fc = 0;
      end
      if (acc) q.push_back(model(pmp_cfg, pmp_addr, priv_mode, bus.req_addr, bus.req_type));
    end
  end

  task automatic set_rgn(input int i, input logic [7:0] c, input logic [31:0] v);
    pmp_cfg[8*i +: 8]        = c;
    pmp_addr[XLEN*i +: XLEN] = v;
  endtask

  task automatic req(input logic [31:0] ad, input logic [2:0] ty, input logic [1:0] pv);
    bit ok;
    int n;
    n = 0;
    bus.req_valid = 1; bus.req_addr = ad; bus.req_type = ty; priv_mode = pv;
    do begin
      @(negedge aclk); ok = bus.req_ready;
      @(posedge aclk); #1; n++;
    end while (!ok && n < 20);
    if (!ok) chk("accept_timeout", 0, 1);
    bus.req_valid = 0;
  endtask

  task automatic rsp_is(input string name, input logic al, input logic mt, input logic [3:0] rg);
    @(negedge aclk);
    chk({name, "_valid"}, bus.rsp_valid, 1);
    chk({name, "_allow"}, bus.rsp_allow, al);
    chk({name, "_match"}, bus.rsp_match, mt);
    chk({name, "_region"}, bus.rsp_region, rg);
    @(posedge aclk); #1;
  endtask

  initial begin
    logic [NR*8-1:0]    tc;
    logic [NR*XLEN-1:0] ta;
    exp_t               e;
    logic [7:0]         c;
    logic [31:0]        v;

    pmp_cfg = '0; pmp_addr = '0; priv_mode = PRIV_U; fault_clear = 0;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_type = '0; bus.rsp_ready = 1;

    // Hand-computed pins on the reference model
    tc = '0; ta = '0;
    tc[7:0] = 8'h1D; ta[31:0] = 32'h1FF;
    e = model(tc, ta, PRIV_U, 32'hFFC, ACC_R);
    chk("pin_napot_in", {e.allow, e.match, e.region}, 6'b11_0000);
    e = model(tc, ta, PRIV_U, 32'h1000, ACC_R);
    chk("pin_napot_out", {e.allow, e.match}, 2'b00);
    tc = '0; ta = '0;
    ta[31:0] = 32'h400; tc[15:8] = 8'h0B; ta[63:32] = 32'h800;
    e = model(tc, ta, PRIV_U, 32'h1FFC, ACC_W);
    chk("pin_tor", {e.allow, e.match, e.region}, 6'b11_0001);
    tc = '0; ta = '0;
    tc[7:0] = 8'h18; ta[31:0] = 32'hFFFF_FFFF;
    e = model(tc, ta, PRIV_U, 32'hDEAD_BEEC, ACC_R);
    chk("pin_napot_all", {e.allow, e.match}, 2'b01);

    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_allow", bus.rsp_allow, 0);
    chk("rst_rsp_match", bus.rsp_match, 0);
    chk("rst_rsp_region", bus.rsp_region, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_fault", {fault_valid, fault_addr, fault_type, fault_count}, 0);
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;

    // No regions configured
    req(32'h1000, ACC_R, PRIV_U); rsp_is("u_nocfg", 0, 0, 0);
    req(32'h1000, ACC_R, PRIV_M); rsp_is("m_nocfg", 1, 0, 0);

    // 4 KiB NAPOT at 0, R|X
    set_rgn(0, 8'h1D, 32'h1FF);
    req(32'hFFC,  ACC_R, PRIV_U); rsp_is("napot_r", 1, 1, 0);
    req(32'hFFC,  ACC_W, PRIV_U); rsp_is("napot_w", 0, 1, 0);
    req(32'h1000, ACC_R, PRIV_U); rsp_is("napot_out", 0, 0, 0);

    // TOR region 1 over [0x1000,0x2000) shadowing NA4 region 2 at 0x1000
    set_rgn(0, 8'h00, 32'h400);
    set_rgn(1, 8'h0B, 32'h800);
    set_rgn(2, 8'h14, 32'h400);
    req(32'h1000, ACC_W, PRIV_U); rsp_is("tor_prio", 1, 1, 1);
    set_rgn(0, 8'h00, 32'h800);
    set_rgn(1, 8'h0B, 32'h400);
    req(32'h1000, ACC_W, PRIV_U); rsp_is("tor_inv_na4", 0, 1, 2);
    req(32'h1800, ACC_W, PRIV_U); rsp_is("tor_inv_none", 0, 0, 0);

    // Locked entry binds M-mode
    pmp_cfg = '0; pmp_addr = '0;
    set_rgn(0, 8'h99, 32'h1FF);
    req(32'h0, ACC_W, PRIV_M); rsp_is("m_locked", 0, 1, 0);
    set_rgn(0, 8'h19, 32'h1FF);
    req(32'h0, ACC_W, PRIV_M); rsp_is("m_unlocked", 1, 1, 0);

    // Backpressure: one accepted, the next held while rsp_ready is low
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_addr = 32'h100; bus.req_type = ACC_R; priv_mode = PRIV_M;
    @(posedge aclk); #1;
    bus.req_addr = 32'h104;
    repeat (5) begin
      @(negedge aclk);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_rsp_allow", bus.rsp_allow, 1);
      @(posedge aclk); #1;
    end
    bus.rsp_ready = 1;
    @(posedge aclk); #1; bus.req_addr = 32'h108;
    @(posedge aclk); #1; bus.req_addr = 32'h10C;
    @(posedge aclk); #1; bus.req_valid = 0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("stall_drained", q.size(), 0);
    @(posedge aclk); #1;

    // Fault capture, clear-with-denial, saturation
    pmp_cfg = '0; pmp_addr = '0;
    fault_clear = 1; @(posedge aclk); #1; fault_clear = 0;
    req(32'h10, ACC_R, PRIV_U);
    req(32'h20, ACC_R, PRIV_U);
    req(32'h30, ACC_R, PRIV_U);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("flt3_valid", fault_valid, 1);
    chk("flt3_addr", fault_addr, 32'h10);
    chk("flt3_count", fault_count, 3);
    @(posedge aclk); #1;
    req(32'h40, ACC_W, PRIV_U);
    fault_clear = 1; @(posedge aclk); #1; fault_clear = 0;
    @(negedge aclk);
    chk("fltclr_valid", fault_valid, 1);
    chk("fltclr_addr", fault_addr, 32'h40);
    chk("fltclr_type", fault_type, ACC_W);
    chk("fltclr_count", fault_count, 1);
    @(posedge aclk); #1;
    repeat (9) req(32'h50, ACC_R, PRIV_U);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("flt_sat", fault_count, CMAX);
    chk("flt_sat_addr", fault_addr, 32'h40);
    @(posedge aclk); #1;

    // Reset with a response pending
    bus.rsp_ready = 0;
    req(32'h60, ACC_R, PRIV_U);
    aresetn = 0;
    repeat (2) begin @(posedge aclk); #1; end
    aresetn = 1; bus.rsp_ready = 1;
    repeat (3) begin @(posedge aclk); #1; end
    @(negedge aclk);
    chk("postrst_rsp_valid", bus.rsp_valid, 0);
    chk("postrst_fault", {fault_valid, fault_count}, 0);
    @(posedge aclk); #1;

    // Randomised traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 50 == 0) begin
        for (int i = 0; i < NR; i++) begin
          c = 8'($urandom);
          v = $urandom_range(0, 32'h1000);
          if (c[4:3] == 2'd3) begin
            v = v | ((32'd1 << $urandom_range(0, 10)) - 1);
            if ($urandom % 16 == 0) v = 32'hFFFF_FFFF;
          end
          set_rgn(i, c, v);
        end
      end
      bus.req_valid = ($urandom % 4) != 0;
      bus.req_addr  = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 32'h5000));
      case ($urandom % 5)
        0:       bus.req_type = 3'($urandom);
        1:       bus.req_type = ACC_W;
        2:       bus.req_type = ACC_X;
        default: bus.req_type = ACC_R;
      endcase
      priv_mode     = 2'($urandom);
      bus.rsp_ready = ($urandom % 4) != 0;
      fault_clear   = ($urandom % 16) == 0;
      @(posedge aclk); #1;
    end

    bus.req_valid = 0; bus.rsp_ready = 1; fault_clear = 0;
    repeat (3) begin @(posedge aclk); #1; end
    @(negedge aclk);
    chk("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/friscv_pmp_checker.md
Name: friscv_pmp_checker

Overview:
- Parametrised successor to the pass-through MPU. Performs RISC-V PMP checks (OFF/TOR/NA4/NAPOT, lock bit, privilege-dependent rules) on one memory request stream.
- Result is returned through a one-deep registered valid/ready response stage.
- Captures the first faulting access in sticky registers for trap handling.
- Instantiated once on the instruction path and once on the data path, between the fetch/LSU address generation and the AXI4 master.

Parameters:
- XLEN, 32, register width; pmpaddr entries are XLEN wide and hold physical address bits [XLEN+1:2].
- AXI_ADDR_W, 32, request address width; must be ≤ XLEN+2.
- NB_REGIONS, 16, number of implemented PMP entries, 1..16.
- FAULT_CNT_W, 16, width of the saturating fault counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- pmp_cfg  in  NB_REGIONS*8  pmpNcfg bytes; entry i at [8i+7:8i]; bits: L=7, A=4:3, X=2, W=1, R=0
- pmp_addr  in  NB_REGIONS*XLEN  pmpaddrN; entry i at [XLEN*i+XLEN-1:XLEN*i]
- priv_mode  in  2  current privilege: 0=U, 1=S, 3=M
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_addr  in  AXI_ADDR_W  byte address
- req_type  in  3  one-hot access type: [0]=R, [1]=W, [2]=X
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_allow  out  1  1 = access permitted
- rsp_match  out  1  1 = some region matched
- rsp_region  out  4  index of the matching region (0 when rsp_match=0)
- fault_valid  out  1  sticky: a denied response has been captured
- fault_addr  out  AXI_ADDR_W  captured address
- fault_type  out  3  captured req_type
- fault_count  out  FAULT_CNT_W  saturating count of denied responses
- fault_clear  in  1  clears fault_valid and fault_count

Behaviour:
- Reset: rsp_valid=0, rsp_allow=0, rsp_match=0, rsp_region=0, fault_valid=0, fault_addr=0, fault_type=0, fault_count=0. req_ready is combinational and therefore 1 out of reset.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready.
  - Accept on req_valid && req_ready.
  - Response registered on the accept edge: latency 1 cycle, throughput 1 per cycle.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - rsp_valid drops after the handshake if no new accept occurs in that cycle.
- Config, priv_mode and the request are sampled combinationally in the accept cycle. Later config changes never alter a pending response.
- Compare address: a = zero-extended req_addr[AXI_ADDR_W-1:2], XLEN bits.
- Region i match by A field:
  - OFF (0): never matches.
  - TOR (1): lo ≤ a < pmp_addr[i], where lo = pmp_addr[i-1] (lo = 0 for i = 0). If lo ≥ pmp_addr[i], no match.
  - NA4 (2): a == pmp_addr[i].
  - NAPOT (3): mask = pmp_addr[i] ^ (pmp_addr[i]+1); match when (a | mask) == (pmp_addr[i] | mask). Region size is 2^(t+3) bytes, t = trailing ones. All-ones pmp_addr covers the whole space.
- Priority: the lowest-index matching region wins; others are ignored.
- Permission, for the winning region:
  - priv_mode ≠ M: allow = |(req_type & {X,W,R}).
  - priv_mode = M and L = 0: allow = 1.
  - priv_mode = M and L = 1: same rule as non-M.
  - Reserved W=1, R=0 combination: treat R and W as 0 (X unaffected).
- No match: allow = 1 if priv_mode = M, else 0.
- Illegal req_type (not one-hot, including 0): allow = 0, regardless of match.
- Fault capture, evaluated at the response handshake with rsp_allow = 0:
  - If fault_valid = 0: latch fault_addr and fault_type, set fault_valid.
  - fault_count increments by 1, saturating at all-ones.
- fault_clear:
  - Clears fault_valid and fault_count next cycle.
  - Clear and denied handshake in the same cycle: the new fault wins (fault_valid = 1, fields updated, count = 1).
- Reset asserted mid-transaction: any pending response is dropped, with no response after reset release.

Decomposition:
- Package friscv_pmp_pkg holds:
  - A-field encodings: PMP_OFF, PMP_TOR, PMP_NA4, PMP_NAPOT.
  - cfg bit positions: PMP_L, PMP_A_MSB/LSB, PMP_X, PMP_W, PMP_R.
  - priv constants: PRIV_U/S/M.
  - access one-hot constants: ACC_R/W/X.
- Sub-module friscv_pmp_region: combinational single-entry matcher with inputs cfg, addr, prev_addr and a; outputs match and rwx. Instantiated NB_REGIONS times through generate; the top-level module owns the priority encoder, handshake and fault registers.

Test Plan:
- Reset release, no config → req_ready=1; U-mode R @0x1000 → rsp_valid 1 cycle later, allow=0, match=0; M-mode → allow=1.
- Region 0 NAPOT, pmp_addr=0x000001FF (4 KiB @0x0), cfg=R|X → U-mode R @0xFFC allowed, region=0; W @0xFFC denied; R @0x1000 denied, match=0.
- Region 1 TOR over region 0 pmp_addr 0x400 and region 1 pmp_addr 0x800 (0x1000–0x1FFF), cfg=R|W, plus overlapping region 2 NA4 @0x1000 with X only → W @0x1000 allowed via region 1 (priority); region 1 with lo=0x800, hi=0x400 never matches.
- M-mode with region 0 L=1, R only → W @0x0 denied; L cleared → allowed.
- rsp_ready held low 5 cycles with back-to-back requests → req_ready=0, first response stable, no request lost; rsp_ready=1 → one response per cycle.
- Three denied responses → fault_addr = first address, fault_count=3; fault_clear together with a fourth denial → fault_valid=1, address = fourth, count=1.
